// File: rtl/gray_codec_pkg.sv
// Shared constants for the Gray/binary converter pipeline: mode encodings,
// legal parameter ranges and the per-stage bit-slice width helper.
package gray_codec_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  localparam int STAGES_MIN     = 1;
  localparam int STAGES_MAX     = 4;
  localparam int DATA_WIDTH_MIN = 2;
  localparam int DATA_WIDTH_MAX = 64;

  // Bits handled by each stage; the last stages may get fewer (or none) when
  // the width does not divide evenly.
  function automatic int slice_width(input int data_width, input int stages);
    return (data_width + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline slice: valid/ready register plus the part of the XOR prefix
// that falls in this stage's bit slice (err bit only with GRAY_STEP_CHECK_EN).
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGE_IDX  = 0,
  parameter int SLICE_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
`ifdef GRAY_STEP_CHECK_EN
  input  logic                  err_i,
  output logic                  err_o,
`endif
  output logic                  valid_o,
  output logic                  mode_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
);

  logic                  valid_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  load;

  assign load = !valid_q || ready_i;

  // Gray-to-binary slices run from the MSB down (bit i needs the finished bit
  // i+1); binary-to-Gray slices run from the LSB up (bit i needs raw bit i+1).
  always_comb begin
    // NOTE: default assignment first so every path writes data_d -- no latch.
    data_d = data_i;
    if (mode_i == MODE_B2G) begin
      for (int i = 0; i < DATA_WIDTH - 1; i++) begin
        if (i / SLICE_W == STAGE_IDX) data_d[i] = data_d[i] ^ data_d[i+1];
      end
    end else begin
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
        if ((DATA_WIDTH - 1 - i) / SLICE_W == STAGE_IDX) data_d[i] = data_d[i] ^ data_d[i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so stages update in lockstep.
    if (reset) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_G2B;
      // NOTE: data is reset too, so out_data reads 0 after reset, not stale bits.
      data_q  <= '0;
    end else if (load) begin
      valid_q <= valid_i;
      if (valid_i) begin
        mode_q <= mode_i;
        data_q <= data_d;
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (load && valid_i) err_q <= err_i;
  end

  assign err_o = err_q;
`endif

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Gray<->binary converter, STAGES-deep elastic pipeline with collapsing bubbles.
// Optional GRAY_STEP_CHECK_EN adds out_err: Hamming step > 1 between mode-0 inputs.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic                  out_err
`endif
);

  localparam int SLICE_W = slice_width(DATA_WIDTH, STAGES);

  // Index 0 is the input port, index k+1 the output of stage k.
  logic [STAGES:0]                 valid_s;
  logic [STAGES:0]                 mode_s;
  logic [STAGES:0][DATA_WIDTH-1:0] data_s;
  logic [STAGES-1:0]               ds_ready;

  assign valid_s[0] = in_valid;
  assign mode_s[0]  = in_mode;
  assign data_s[0]  = in_data;

  // Stage k may load when any stage after it is empty or the sink is taking a
  // beat; derived from registered valids so there is no ripple through stages.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ds_ready[k] = out_ready;
      for (int j = k + 1; j < STAGES; j++) begin
        if (!valid_s[j+1]) ds_ready[k] = 1'b1;
      end
    end
  end

  assign in_ready = !valid_s[1] || ds_ready[0];

`ifdef GRAY_STEP_CHECK_EN
  logic [STAGES:0]           err_s;
  logic [DATA_WIDTH-1:0]     hist_q;
  logic                      hist_valid_q;
  logic                      step_err;

  assign step_err = hist_valid_q && ($countones(in_data ^ hist_q) > 1);
  assign err_s[0] = (in_mode == MODE_G2B) && step_err;

  // History tracks accepted Gray-to-binary inputs only.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q       <= '0;
      hist_valid_q <= 1'b0;
    end else if (in_valid && in_ready && in_mode == MODE_G2B) begin
      hist_q       <= in_data;
      hist_valid_q <= 1'b1;
    end
  end

  assign out_err = err_s[STAGES];
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gray_codec_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGE_IDX  (k),
      .SLICE_W    (SLICE_W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .valid_i (valid_s[k]),
      .mode_i  (mode_s[k]),
      .data_i  (data_s[k]),
`ifdef GRAY_STEP_CHECK_EN
      .err_i   (err_s[k]),
      .err_o   (err_s[k+1]),
`endif
      .valid_o (valid_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .data_o  (data_s[k+1]),
      .ready_i (ds_ready[k])
    );
  end

  assign out_valid = valid_s[STAGES];
  assign out_mode  = mode_s[STAGES];
  assign out_data  = data_s[STAGES];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: directed 4-bit/2-stage vectors plus a queue model
// run against 16-bit instances with STAGES 1..4 and random backpressure.
module tb_gray_codec_pipe;
  import gray_codec_pkg::*;

  typedef struct {
    logic        mode;
    logic [63:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   rnd_done = 0;
  logic reset    = 1'b1;
  logic rreset   = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] g2b(input logic [63:0] g, input int w);
    logic [63:0] b;
    b = '0;
    b[w-1] = g[w-1];
    for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [63:0] b2g(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- directed DUT: DATA_WIDTH=4, STAGES=2 ----------------
  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
  logic [3:0] a_in_data, a_out_data;
`ifdef GRAY_STEP_CHECK_EN
  logic       a_out_err;
`endif

  gray_codec_pipe #(.DATA_WIDTH(4), .STAGES(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_mode   (a_in_mode),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_mode  (a_out_mode),
`ifdef GRAY_STEP_CHECK_EN
    .out_err   (a_out_err),
`endif
    .out_data  (a_out_data)
  );

  logic       bm[8];
  logic [3:0] bd[8];
  logic [3:0] be[8];
  logic       berr[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back beats with out_ready high: beat j must appear after tick j+1.
  task automatic run_burst(input int n, input string tag);
    a_out_ready = 1'b1;
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        a_in_valid = 1'b1;
        a_in_mode  = bm[j];
        a_in_data  = bd[j];
        #1 check({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
      if (j >= 1) begin
        check($sformatf("%s_valid%0d", tag, j - 1), 64'(a_out_valid), 64'd1);
        check($sformatf("%s_data%0d", tag, j - 1), 64'(a_out_data), 64'(be[j-1]));
        check($sformatf("%s_mode%0d", tag, j - 1), 64'(a_out_mode), 64'(bm[j-1]));
`ifdef GRAY_STEP_CHECK_EN
        check($sformatf("%s_err%0d", tag, j - 1), 64'(a_out_err), 64'(berr[j-1]));
`endif
      end
    end
    tick();
    check({tag, "_drained"}, 64'(a_out_valid), 64'd0);
  endtask

  initial begin
    a_in_valid  = 1'b1;
    a_in_mode   = MODE_G2B;
    a_in_data   = 4'b0110;
    a_out_ready = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_out_data", 64'(a_out_data), 64'd0);
    check("rst_out_mode", 64'(a_out_mode), 64'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("rst_out_err", 64'(a_out_err), 64'd0);
`endif
    tick();
    tick();
    check("rst_ignored_beat", 64'(a_out_valid), 64'd0);

    check("model_g2b", g2b(64'hB, 4), 64'hD);
    check("model_b2g", b2g(64'hD), 64'hB);

    // Single Gray-to-binary beat, exactly two cycles of latency.
    a_in_valid = 1'b1;
    a_in_mode  = MODE_G2B;
    a_in_data  = 4'b1011;
    #1 check("lat_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 1'b0;
    check("lat_early", 64'(a_out_valid), 64'd0);
    tick();
    check("lat_valid", 64'(a_out_valid), 64'd1);
    check("lat_data", 64'(a_out_data), 64'b1101);
    check("lat_mode", 64'(a_out_mode), 64'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("lat_err", 64'(a_out_err), 64'd0);
`endif
    tick();
    check("lat_gone", 64'(a_out_valid), 64'd0);

    // Alternating modes at full rate.
    bm   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bd   = '{4'b1101, 4'b1011, 4'b0011, 4'b0110, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    be   = '{4'b1011, 4'b1101, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    berr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    run_burst(5, "alt");

    // Backpressure: capacity of two, third beat enters as the first leaves.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = MODE_B2G;
    a_in_data   = 4'b0001;
    #1 check("full_acc0", 64'(a_in_ready), 64'd1);
    tick();
    a_in_data = 4'b0010;
    #1 check("full_acc1", 64'(a_in_ready), 64'd1);
    tick();
    a_in_data = 4'b0011;
    #1 check("full_block", 64'(a_in_ready), 64'd0);
    check("full_head", 64'(a_out_data), 64'b0001);
    tick();
    check("stall_valid", 64'(a_out_valid), 64'd1);
    check("stall_data", 64'(a_out_data), 64'b0001);
    check("stall_block", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    #1 check("same_cycle_accept", 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 1'b0;
    check("full_second", 64'(a_out_data), 64'b0011);
    check("full_second_v", 64'(a_out_valid), 64'd1);
    tick();
    check("full_third", 64'(a_out_data), 64'b0010);
    check("full_third_v", 64'(a_out_valid), 64'd1);
    tick();
    check("full_empty", 64'(a_out_valid), 64'd0);

    // Reset with two beats in flight.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = MODE_G2B;
    a_in_data   = 4'b0101;
    tick();
    a_in_mode = MODE_B2G;
    a_in_data = 4'b1010;
    tick();
    check("flight_pre", 64'(a_out_valid), 64'd1);
    reset     = 1'b1;
    a_in_data = 4'b0111;
    tick();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    check("flush_valid", 64'(a_out_valid), 64'd0);
    check("flush_ready", 64'(a_in_ready), 64'd1);
    check("flush_data", 64'(a_out_data), 64'd0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("no_stale%0d", i), 64'(a_out_valid), 64'd0);
    end

    // Step check sequence on fresh history.
    bm   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bd   = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    be   = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    berr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_burst(3, "step");

    for (int i = 0; i < 20000 && rnd_done < 4; i++) @(posedge clk);
    check("rnd_done", 64'(rnd_done), 64'd4);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // ---------------- random DUTs: DATA_WIDTH=16, STAGES=1..4 ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rreset = 1'b0;
  end

  for (genvar gi = 1; gi <= 4; gi++) begin : g_rnd
    localparam int S = gi;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [15:0] in_data, out_data;
`ifdef GRAY_STEP_CHECK_EN
    logic        out_err;
`endif

    gray_codec_pipe #(.DATA_WIDTH(16), .STAGES(S)) u_dut (
      .clk       (clk),
      .reset     (rreset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mode  (out_mode),
`ifdef GRAY_STEP_CHECK_EN
      .out_err   (out_err),
`endif
      .out_data  (out_data)
    );

    initial begin
      exp_t        q[$];
      exp_t        e;
      logic [15:0] hist;
      logic [15:0] last;
      logic        hist_v;
      logic        exp_ov;
      int          cyc;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      hist      = '0;
      last      = '0;
      hist_v    = 1'b0;
      cyc       = 0;
      while (rreset) @(negedge clk);
      for (int n = 0; n < 460; n++) begin
        @(negedge clk);
        if (n < 420) begin
          in_valid  = ($urandom_range(0, 3) != 0);
          in_mode   = 1'($urandom_range(0, 1));
          in_data   = ($urandom_range(0, 1) != 0) ? (last ^ (16'd1 << $urandom_range(0, 15)))
                                                  : 16'($urandom());
          out_ready = ($urandom_range(0, 2) != 0);
        end else begin
          in_valid  = 1'b0;
          out_ready = 1'b1;
        end
        #1;
        check($sformatf("rnd%0d_in_ready", S), 64'(in_ready),
              64'((q.size() < S) || out_ready));
        exp_ov = (q.size() > 0) && (cyc - q[0].acc >= S);
        check($sformatf("rnd%0d_out_valid", S), 64'(out_valid), 64'(exp_ov));
        if (out_valid && exp_ov) begin
          check($sformatf("rnd%0d_data", S), 64'(out_data), q[0].data);
          check($sformatf("rnd%0d_mode", S), 64'(out_mode), 64'(q[0].mode));
`ifdef GRAY_STEP_CHECK_EN
          check($sformatf("rnd%0d_err", S), 64'(out_err), 64'(q[0].err));
`endif
        end
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          e.mode = in_mode;
          e.data = in_mode ? b2g(64'(in_data)) : g2b(64'(in_data), 16);
          e.err  = 1'b0;
          e.acc  = cyc;
          if (!in_mode) begin
            e.err  = hist_v && ($countones(in_data ^ hist) > 1);
            hist   = in_data;
            hist_v = 1'b1;
          end
          q.push_back(e);
          last = in_data;
        end
        cyc++;
      end
      check($sformatf("rnd%0d_drain", S), 64'(q.size()), 64'd0);
      rnd_done++;
    end
  end

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width (legal 2..64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth and latency in cycles (legal 1..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input beat offered.
REQ-006 SHALL have port in_ready, output, 1, input beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_mode, input, 1, 0 = Gray-to-binary, 1 = binary-to-Gray.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, word to convert.
REQ-009 SHALL have port out_valid, output, 1, result beat present.
REQ-010 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-011 SHALL have port out_mode, output, 1, in_mode of the beat being presented.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, converted word.
REQ-013 SHALL have port out_err, output, 1, step-check flag; present only with GRAY_STEP_CHECK_EN.

Function
REQ-014 SHALL convert Gray-to-binary as bin[MSB] = gray[MSB], bin[i] = bin[i+1] ^ gray[i] for i from MSB-1 down to 0.
REQ-015 SHALL convert binary-to-Gray as gray = bin ^ (bin >> 1).
REQ-016 SHALL be a STAGES-deep register pipeline; each stage holds valid, mode and partial data.
REQ-017 SHALL present an accepted beat on out_data no earlier than STAGES cycles after acceptance.
REQ-018 SHALL, with out_ready held high, achieve exactly STAGES cycles of latency and one beat per cycle.
REQ-019 SHALL advance stage k when stage k+1 is empty or advancing, so bubbles collapse.
REQ-020 SHALL hold capacity of exactly STAGES beats; in_ready = !stage0_valid || stage0_advancing.
REQ-021 SHALL keep out_valid, out_data, out_mode and out_err stable while out_valid && !out_ready.
REQ-022 SHALL preserve beat order, and SHALL allow mode to change on any beat with no drain.
REQ-023 SHALL, on simultaneous accept at input and consume at output when full, accept the new beat in the same cycle.

Reset
REQ-024 SHALL, while reset is high at a clock edge, clear all stage valids, giving out_valid = 0 and in_ready = 1 from the next cycle.
REQ-025 SHALL reset out_data to 0, out_mode to 0 and out_err to 0.
REQ-026 SHALL drop in-flight beats on mid-operation reset, and SHALL ignore in_valid in the reset cycle.

Configuration
REQ-027 SHALL support macro GRAY_STEP_CHECK_EN.
REQ-028 SHALL, with GRAY_STEP_CHECK_EN defined, compare each accepted mode-0 input against the previous accepted mode-0 input.
REQ-029 SHALL, under the same macro, raise out_err with that beat's output when the Hamming distance is greater than 1.
REQ-030 SHALL never flag the first mode-0 beat after reset, and SHALL leave the check history unchanged on mode-1 beats.
REQ-031 SHALL, without GRAY_STEP_CHECK_EN, omit the out_err port and the history register entirely.

Structure
REQ-032 SHALL place mode encodings (MODE_G2B = 0, MODE_B2G = 1) and STAGES legal-range constants in package gray_codec_pkg.
REQ-033 SHALL use one sub-module, gray_codec_stage, instantiated STAGES times: a register slice with valid/ready plus a combinational partial XOR-prefix over its bit slice.

Verification
REQ-034 SHALL cover: DATA_WIDTH=4, mode 0, in_data 4'b1011 -> out_data 4'b1101, out_mode 0, exactly STAGES cycles later.
REQ-035 SHALL cover: DATA_WIDTH=4, mode 1, in_data 4'b1101 -> out_data 4'b1011; then alternating modes back-to-back at one beat per cycle, all results in order.
REQ-036 SHALL cover: STAGES=2, out_ready low, offer 3 beats -> 2 accepted, in_ready low on the third; out_ready high -> third accepted the same cycle the first is consumed.
REQ-037 SHALL cover: GRAY_STEP_CHECK_EN, mode 0 inputs 4'b0000, 4'b0001, 4'b0010 -> out_err 0, 0, 1.
REQ-038 SHALL cover: reset asserted with 2 beats in flight -> out_valid 0 the next cycle and no stale beat emitted afterwards.
REQ-039 SHALL cover: random stimulus against the REQ-014/REQ-015 reference model, with out_ready toggling randomly, for DATA_WIDTH 16 and STAGES 1..4.
